// File: rtl/pe_link_pkg.sv
// Shared types and constants for the pe_link traffic generator/checker:
// FSM states, LFSR polynomial and lane-word field offsets.
package pe_link_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int SEQ_W  = 16;
    localparam int LFSR_W = 32;

    // Right-shift Galois taps for x^32 + x^22 + x^2 + x + 1
    localparam logic [LFSR_W-1:0] LFSR_POLY = 32'h8020_0003;

    // Field positions counted down from the word MSB
    localparam int VALID_OFS = 1;
    localparam int SEQ_OFS   = 2;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        logic [LFSR_W-1:0] nxt;
        nxt = {1'b0, s[LFSR_W-1:1]};
        if (s[0]) begin
            nxt = nxt ^ LFSR_POLY;
        end else begin
            nxt = nxt;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pe_link_lfsr.sv
// 32-bit Galois LFSR with seed load and single-step advance; one instance
// drives the generator, another tracks the checker's expectation.
module pe_link_lfsr
    import pe_link_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_2468
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              advance,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_d;

    // Next-state selection: load wins over advance
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = SEED;
        end else if (advance) begin
            state_d = lfsr_step(state_q);
        end else begin
            state_d = state_q;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/pe_link_tg.sv
// Lane traffic generator and in-order checker for a tile under test.
// Optional build macro PE_LINK_TG_ERRINJ_EN adds inj_err to corrupt tx_data bit 0.
module pe_link_tg
    import pe_link_pkg::*;
#(
    parameter int          DATA_WIDTH = 130,
    parameter logic [31:0] SEED       = 32'hACE1_2468,
    parameter int          TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
`ifdef PE_LINK_TG_ERRINJ_EN
    input  logic                  inj_err,
`endif
    input  logic [15:0]           num_words,
    output logic                  tile_start,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic [DATA_WIDTH-1:0] rx_data,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic [15:0]           rx_count,
    output logic [15:0]           err_count,
    output logic [15:0]           first_err_seq
);

    localparam int          PAT_W    = DATA_WIDTH - 1 - SEQ_W;
    localparam int          REPS     = (PAT_W + LFSR_W - 1) / LFSR_W;
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

    // Word = {valid, seq, LFSR state replicated from the LSB and truncated}
    function automatic logic [DATA_WIDTH-1:0] make_word(input logic [SEQ_W-1:0]  seq,
                                                        input logic [LFSR_W-1:0] st);
        logic [REPS*LFSR_W-1:0] rep;
        rep = {REPS{st}};
        return {1'b1, seq, rep[PAT_W-1:0]};
    endfunction

    state_e                  state_q, state_d;
    logic [15:0]             num_q, num_d;
    logic [SEQ_W-1:0]        seq_q, seq_d;
    logic [31:0]             drain_cnt_q, drain_cnt_d;
    logic                    tile_start_q, tile_start_d;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    timeout_q, timeout_d;
    logic [15:0]             rx_count_q, rx_count_d;
    logic [15:0]             err_count_q, err_count_d;
    logic [15:0]             first_err_seq_q, first_err_seq_d;
    logic                    err_seen_q, err_seen_d;
    logic [SEQ_W-1:0]        exp_seq_q, exp_seq_d;

    logic                    gen_load, gen_adv, chk_load, chk_adv;
    logic [LFSR_W-1:0]       gen_state, chk_state;
    logic                    rx_valid, word_err;
    logic [SEQ_W-1:0]        rx_seq;
    logic [DATA_WIDTH-1:0]   exp_word;

    pe_link_lfsr #(.SEED(SEED)) u_gen_lfsr (
        .clk     (clk),
        .reset   (reset),
        .load    (gen_load),
        .advance (gen_adv),
        .state   (gen_state)
    );

    pe_link_lfsr #(.SEED(SEED)) u_chk_lfsr (
        .clk     (clk),
        .reset   (reset),
        .load    (chk_load),
        .advance (chk_adv),
        .state   (chk_state)
    );

    // Checker and run-control next-state logic
    always_comb begin
        state_d         = state_q;
        num_d           = num_q;
        seq_d           = seq_q;
        drain_cnt_d     = drain_cnt_q;
        tile_start_d    = tile_start_q;
        tx_data_d       = tx_data_q;
        done_d          = 1'b0;
        timeout_d       = timeout_q;
        rx_count_d      = rx_count_q;
        err_count_d     = err_count_q;
        first_err_seq_d = first_err_seq_q;
        err_seen_d      = err_seen_q;
        exp_seq_d       = exp_seq_q;
        gen_load        = 1'b0;
        gen_adv         = 1'b0;
        chk_load        = 1'b0;
        chk_adv         = 1'b0;
        word_err        = 1'b0;
        rx_valid        = rx_data[DATA_WIDTH-VALID_OFS];
        rx_seq          = rx_data[DATA_WIDTH-SEQ_OFS -: SEQ_W];
        exp_word        = make_word(exp_seq_q, chk_state);

        // Only arrival order matters: expectation advances per received valid word
        if ((state_q == ST_RUN || state_q == ST_DRAIN) && rx_valid) begin
            if (rx_count_q == num_q) begin
                word_err = 1'b1;
            end else begin
                rx_count_d = rx_count_q + 16'd1;
                exp_seq_d  = exp_seq_q + 16'd1;
                chk_adv    = 1'b1;
                word_err   = (rx_data != exp_word);
            end
        end else begin
            word_err = 1'b0;
        end

        if (word_err) begin
            if (err_count_q != 16'hFFFF) begin
                err_count_d = err_count_q + 16'd1;
            end else begin
                err_count_d = err_count_q;
            end
            if (!err_seen_q) begin
                err_seen_d      = 1'b1;
                first_err_seq_d = rx_seq;
            end else begin
                err_seen_d = err_seen_q;
            end
        end else begin
            err_count_d = err_count_d;
        end

        case (state_q)
            ST_IDLE: begin
                tile_start_d = 1'b0;
                tx_data_d    = '0;
                if (start) begin
                    num_d           = num_words;
                    seq_d           = 16'd0;
                    timeout_d       = 1'b0;
                    rx_count_d      = 16'd0;
                    err_count_d     = 16'd0;
                    first_err_seq_d = 16'hFFFF;
                    err_seen_d      = 1'b0;
                    exp_seq_d       = 16'd0;
                    gen_load        = 1'b1;
                    chk_load        = 1'b1;
                    if (num_words != 16'd0) begin
                        state_d      = ST_RUN;
                        tile_start_d = 1'b1;
                        tx_data_d    = make_word(16'd0, SEED);
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // gen_state holds the LFSR value of the word currently on tx_data
                if (seq_q == 16'(num_q - 16'd1)) begin
                    state_d     = ST_DRAIN;
                    tx_data_d   = '0;
                    drain_cnt_d = 32'd0;
                end else begin
                    seq_d     = seq_q + 16'd1;
                    gen_adv   = 1'b1;
                    tx_data_d = make_word(seq_q + 16'd1, lfsr_step(gen_state));
                end
            end
            ST_DRAIN: begin
                if (rx_count_d == num_q) begin
                    state_d      = ST_DONE;
                    done_d       = 1'b1;
                    tile_start_d = 1'b0;
                end else if (drain_cnt_q == TMO_LAST) begin
                    state_d      = ST_DONE;
                    done_d       = 1'b1;
                    timeout_d    = 1'b1;
                    tile_start_d = 1'b0;
                end else begin
                    drain_cnt_d = drain_cnt_q + 32'd1;
                end
            end
            ST_DONE: begin
                state_d      = ST_IDLE;
                tile_start_d = 1'b0;
                tx_data_d    = '0;
            end
            default: begin
                state_d      = ST_IDLE;
                tile_start_d = 1'b0;
                tx_data_d    = '0;
            end
        endcase

        busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    end

    // State and registered-output flops
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            num_q           <= 16'd0;
            seq_q           <= 16'd0;
            drain_cnt_q     <= 32'd0;
            tile_start_q    <= 1'b0;
            tx_data_q       <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            timeout_q       <= 1'b0;
            rx_count_q      <= 16'd0;
            err_count_q     <= 16'd0;
            first_err_seq_q <= 16'hFFFF;
            err_seen_q      <= 1'b0;
            exp_seq_q       <= 16'd0;
        end else begin
            state_q         <= state_d;
            num_q           <= num_d;
            seq_q           <= seq_d;
            drain_cnt_q     <= drain_cnt_d;
            tile_start_q    <= tile_start_d;
            tx_data_q       <= tx_data_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            timeout_q       <= timeout_d;
            rx_count_q      <= rx_count_d;
            err_count_q     <= err_count_d;
            first_err_seq_q <= first_err_seq_d;
            err_seen_q      <= err_seen_d;
            exp_seq_q       <= exp_seq_d;
        end
    end

`ifdef PE_LINK_TG_ERRINJ_EN
    // Corruption hits only the word shown while inj_err is high
    assign tx_data = tx_data_q ^ {{(DATA_WIDTH-1){1'b0}}, (inj_err && (state_q == ST_RUN))};
`else
    assign tx_data = tx_data_q;
`endif

    assign tile_start    = tile_start_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign timeout       = timeout_q;
    assign rx_count      = rx_count_q;
    assign err_count     = err_count_q;
    assign first_err_seq = first_err_seq_q;

endmodule

// File: tb/tb_pe_link_tg.sv
// Directed bench for pe_link_tg: loopback, empty run, drain timeout, dropped
// word, optional error injection and mid-run reset.
module tb_pe_link_tg;

    localparam int          DW     = 130;
    localparam int          PW     = DW - 17;
    localparam logic [31:0] SEED_V = 32'hACE1_2468;

    logic          clk;
    logic          reset;
    logic          start;
    logic          inj_err;
    logic [15:0]   num_words;
    logic          tile_start;
    logic [DW-1:0] tx_data;
    logic [DW-1:0] rx_data;
    logic          busy, done, timeout;
    logic [15:0]   rx_count, err_count, first_err_seq;

    logic [DW-1:0] p1, p2, p3;
    int            mode;
    int            n_checks;
    int            n_errors;

    pe_link_tg #(.DATA_WIDTH(DW), .SEED(SEED_V), .TIMEOUT(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
`ifdef PE_LINK_TG_ERRINJ_EN
        .inj_err       (inj_err),
`endif
        .num_words     (num_words),
        .tile_start    (tile_start),
        .tx_data       (tx_data),
        .rx_data       (rx_data),
        .busy          (busy),
        .done          (done),
        .timeout       (timeout),
        .rx_count      (rx_count),
        .err_count     (err_count),
        .first_err_seq (first_err_seq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Three-stage tile model
    always_ff @(posedge clk) begin
        p1 <= tx_data;
        p2 <= p1;
        p3 <= p2;
    end

    // Lane return: 0 loopback, 1 tied low, 2 loopback with seq 5 dropped
    always_comb begin
        rx_data = p3;
        if (mode == 1) begin
            rx_data = '0;
        end else if (mode == 2 && p3[DW-1] && p3[DW-2 -: 16] == 16'd5) begin
            rx_data = '0;
        end else begin
            rx_data = p3;
        end
    end

    function automatic logic [31:0] tb_step(input logic [31:0] s);
        logic [31:0] r;
        r = s >> 1;
        if (s[0]) begin
            r[31] = ~r[31];
            r[21] = ~r[21];
            r[1]  = ~r[1];
            r[0]  = ~r[0];
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] tb_word(input logic [15:0] seq, input logic [31:0] st);
        logic [DW-1:0] w;
        w = '0;
        w[DW-1] = 1'b1;
        w[DW-2 -: 16] = seq;
        for (int i = 0; i < PW; i++) begin
            w[i] = st[i % 32];
        end
        return w;
    endfunction

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run(input string name, input logic [15:0] n, input int mode_i,
                       input int inj_word, input int exp_lat, input logic [15:0] exp_rx,
                       input logic [15:0] exp_err, input logic [15:0] exp_fes,
                       input logic exp_tmo, output logic ts_seen);
        int lat;
        mode      = mode_i;
        num_words = n;
        start     = 1'b1;
        lat       = 0;
        ts_seen   = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            start   = (c == 3);
            inj_err = (c == inj_word + 1);
            if (c == 1 && n >= 16'd2) begin
                check_eq({name, ".word0"}, tx_data, tb_word(16'd0, SEED_V));
                check_eq({name, ".busy_run"}, DW'(busy), DW'(1'b1));
                check_eq({name, ".timeout_clr"}, DW'(timeout), DW'(1'b0));
            end
            if (c == 2 && n >= 16'd2) begin
                check_eq({name, ".word1"}, tx_data, tb_word(16'd1, tb_step(SEED_V)));
            end
            if (c == int'(n) + 1 && n != 16'd0 && !done) begin
                check_eq({name, ".drain_tx"}, tx_data, '0);
                check_eq({name, ".drain_ts"}, DW'(tile_start), DW'(1'b1));
            end
            if (tile_start) ts_seen = 1'b1;
            if (done) begin
                lat = c;
                break;
            end
        end
        start   = 1'b0;
        inj_err = 1'b0;
        check_eq({name, ".latency"}, DW'(lat), DW'(exp_lat));
        check_eq({name, ".rx_count"}, DW'(rx_count), DW'(exp_rx));
        check_eq({name, ".err_count"}, DW'(err_count), DW'(exp_err));
        check_eq({name, ".first_err_seq"}, DW'(first_err_seq), DW'(exp_fes));
        check_eq({name, ".timeout"}, DW'(timeout), DW'(exp_tmo));
        check_eq({name, ".busy_done"}, DW'(busy), DW'(1'b0));
        check_eq({name, ".ts_done"}, DW'(tile_start), DW'(1'b0));
        @(posedge clk);
        #1;
        check_eq({name, ".done_pulse"}, DW'(done), DW'(1'b0));
    endtask

    initial begin
        logic        ts;
        logic        done_seen;
        logic [31:0] st;
        n_checks  = 0;
        n_errors  = 0;
        mode      = 0;
        reset     = 1'b1;
        start     = 1'b0;
        inj_err   = 1'b0;
        num_words = 16'd0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;

        check_eq("rst.tile_start", DW'(tile_start), DW'(1'b0));
        check_eq("rst.tx_data", tx_data, '0);
        check_eq("rst.busy", DW'(busy), DW'(1'b0));
        check_eq("rst.done", DW'(done), DW'(1'b0));
        check_eq("rst.timeout", DW'(timeout), DW'(1'b0));
        check_eq("rst.rx_count", DW'(rx_count), DW'(16'd0));
        check_eq("rst.err_count", DW'(err_count), DW'(16'd0));
        check_eq("rst.first_err_seq", DW'(first_err_seq), DW'(16'hFFFF));

        // done the cycle after start is sampled, tile never started
        run("empty", 16'd0, 0, -1, 1, 16'd0, 16'd0, 16'hFFFF, 1'b0, ts);
        check_eq("empty.ts_never", DW'(ts), DW'(1'b0));

        // 8 words + 3 pipeline stages + 1 to raise done
        run("loop8", 16'd8, 0, -1, 12, 16'd8, 16'd0, 16'hFFFF, 1'b0, ts);

        // 4 RUN + 16 DRAIN + 1
        run("tmo", 16'd4, 1, -1, 21, 16'd0, 16'd0, 16'hFFFF, 1'b1, ts);

        // words 6..9 compared against expected 5..8: four mismatches
        run("drop5", 16'd10, 2, -1, 27, 16'd9, 16'd4, 16'd6, 1'b1, ts);

`ifdef PE_LINK_TG_ERRINJ_EN
        run("errinj", 16'd5, 0, 2, 9, 16'd5, 16'd1, 16'd2, 1'b0, ts);
`endif

        // Reset while word 3 is on the lane
        mode      = 0;
        num_words = 16'd8;
        start     = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        st = SEED_V;
        for (int k = 0; k < 3; k++) st = tb_step(st);
        check_eq("mid.word3", tx_data, tb_word(16'd3, st));
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("mid.tile_start", DW'(tile_start), DW'(1'b0));
        check_eq("mid.tx_data", tx_data, '0);
        check_eq("mid.busy", DW'(busy), DW'(1'b0));
        check_eq("mid.done", DW'(done), DW'(1'b0));
        check_eq("mid.rx_count", DW'(rx_count), DW'(16'd0));
        check_eq("mid.err_count", DW'(err_count), DW'(16'd0));
        check_eq("mid.first_err_seq", DW'(first_err_seq), DW'(16'hFFFF));
        done_seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (done || busy) done_seen = 1'b1;
        end
        check_eq("mid.no_done", DW'(done_seen), DW'(1'b0));

        run("loop3", 16'd3, 0, -1, 7, 16'd3, 16'd0, 16'hFFFF, 1'b0, ts);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
